// File: rtl/alu_responder_pkg.sv
// Shared encodings between the FSM controller and the ALU responder.
// Op codes travel on the request link; state codes are internal to the responder.
package alu_responder_pkg;

  localparam int DEFAULT_WIDTH = 6;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_MUL = 2'b10,
    OP_AND = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_EXEC = 3'd1,
    ST_MUL  = 3'd2,
    ST_DONE = 3'd3
  } state_e;

  // Bits needed to count 0..w inclusive.
  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/alu_seq_mul.sv
// Shift-add multiplier datapath: start loads operands, WIDTH iterations follow, one per cycle.
// done marks the final iteration cycle; product then already shows the completed sum.
module alu_seq_mul
  import alu_responder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int CNT_W = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               active_q, active_d;

  logic [2*WIDTH-1:0] addend;
  logic [2*WIDTH-1:0] acc_sum;

  always_comb begin
    addend   = mplier_q[0] ? mcand_q : '0;
    acc_sum  = acc_q + addend;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    active_d = active_q;
    if (start) begin
      acc_d    = '0;
      mcand_d  = {{WIDTH{1'b0}}, a};
      mplier_d = b;
      cnt_d    = '0;
      active_d = 1'b1;
    end else if (active_q) begin
      acc_d    = acc_sum;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + 1'b1;
      if (cnt_q == LAST) begin
        active_d = 1'b0;
      end
    end
  end

  // Final partial product is folded in combinationally so the parent can
  // register the result on the same edge as the last iteration.
  assign done    = active_q && (cnt_q == LAST);
  assign product = acc_sum;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      active_q <= 1'b0;
    end else begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
      active_q <= active_d;
    end
  end

endmodule

// File: rtl/alu_responder.sv
// Multi-cycle ALU behind a request/response valid-ready pair; 1 cycle for ADD/SUB/AND, WIDTH for MUL.
// One op in flight: req_ready only in IDLE; the response holds in DONE until rsp_ready.
module alu_responder
  import alu_responder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  input  logic [1:0]       req_op,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_flag,
  output logic             busy
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  op_e              op_q, op_d;
  logic [WIDTH-1:0] rsp_result_q, rsp_result_d;
  logic             rsp_flag_q, rsp_flag_d;

  logic               mul_start;
  logic               mul_done;
  logic [2*WIDTH-1:0] mul_product;

  logic [WIDTH:0]   add_full;
  logic [WIDTH-1:0] exec_result;
  logic             exec_flag;

  alu_seq_mul #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .rst_n   (reset),
    .start   (mul_start),
    .a       (req_a),
    .b       (req_b),
    .done    (mul_done),
    .product (mul_product)
  );

  always_comb begin
    add_full    = {1'b0, a_q} + {1'b0, b_q};
    exec_result = '0;
    exec_flag   = 1'b0;
    case (op_q)
      OP_ADD: begin
        exec_result = add_full[WIDTH-1:0];
        exec_flag   = add_full[WIDTH];
      end
      OP_SUB: begin
        exec_result = a_q - b_q;
        exec_flag   = (a_q < b_q);
      end
      OP_AND: begin
        exec_result = a_q & b_q;
        exec_flag   = ((a_q & b_q) == '0);
      end
      default: begin
        exec_result = '0;
        exec_flag   = 1'b0;
      end
    endcase
  end

  always_comb begin
    state_d      = state_q;
    a_d          = a_q;
    b_d          = b_q;
    op_d         = op_q;
    rsp_result_d = rsp_result_q;
    rsp_flag_d   = rsp_flag_q;
    mul_start    = 1'b0;
    req_ready    = 1'b0;
    rsp_valid    = 1'b0;
    busy         = 1'b1;
    case (state_q)
      ST_IDLE: begin
        req_ready = 1'b1;
        busy      = 1'b0;
        if (req_valid) begin
          a_d  = req_a;
          b_d  = req_b;
          op_d = op_e'(req_op);
          if (op_e'(req_op) == OP_MUL) begin
            mul_start = 1'b1;
            state_d   = ST_MUL;
          end else begin
            state_d = ST_EXEC;
          end
        end
      end
      ST_EXEC: begin
        rsp_result_d = exec_result;
        rsp_flag_d   = exec_flag;
        state_d      = ST_DONE;
      end
      ST_MUL: begin
        if (mul_done) begin
          rsp_result_d = mul_product[WIDTH-1:0];
          rsp_flag_d   = |mul_product[2*WIDTH-1:WIDTH];
          state_d      = ST_DONE;
        end
      end
      ST_DONE: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign rsp_result = rsp_result_q;
  assign rsp_flag   = rsp_flag_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      a_q          <= '0;
      b_q          <= '0;
      op_q         <= OP_ADD;
      rsp_result_q <= '0;
      rsp_flag_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      a_q          <= a_d;
      b_q          <= b_d;
      op_q         <= op_d;
      rsp_result_q <= rsp_result_d;
      rsp_flag_q   <= rsp_flag_d;
    end
  end

endmodule
